// File: rtl/addsub_seq_pkg.sv
// ============================================================================
// Module   : addsub_seq_pkg
// Brief    : Shared types and constants for the nibble-serial add/sub sequencer
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package addsub_seq_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/addsub4_slice.sv
// ============================================================================
// Module   : addsub4_slice
// Brief    : Combinational 4-bit add/subtract slice with external carry chain
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module addsub4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       mode,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout,
  output logic       c3
);

  logic [3:0] w_b_eff;
  logic [3:0] w_low;
  logic [4:0] w_full;

  assign w_b_eff = b ^ {4{mode}};

  // Bit 3 carry-in is the carry out of the lower three bits; needed for overflow.
  assign w_low  = {1'b0, a[2:0]} + {1'b0, w_b_eff[2:0]} + {3'b000, cin};
  assign w_full = {1'b0, a} + {1'b0, w_b_eff} + {4'b0000, cin};

  assign sum  = w_full[3:0];
  assign cout = w_full[4];
  assign c3   = w_low[3];

endmodule

`default_nettype wire

// File: rtl/addsub_nibble_sequencer.sv
// ============================================================================
// Module   : addsub_nibble_sequencer
// Brief    : WIDTH-bit add/sub computed LSB nibble first on one shared 4-bit slice
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module addsub_nibble_sequencer
  import addsub_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_t             r_state;
  state_t             w_next_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_result;
  logic               r_mode;
  logic               r_carry;
  logic               r_cout;
  logic               r_ovf;
  logic               r_zero;

  logic [3:0]         w_sum;
  logic               w_cout;
  logic               w_c3;
  logic               w_accept;
  logic               w_last;
  logic [WIDTH-1:0]   w_shifted;

  addsub4_slice u_slice (
    .a    (r_a[3:0]),
    .b    (r_b[3:0]),
    .mode (r_mode),
    .cin  (r_carry),
    .sum  (w_sum),
    .cout (w_cout),
    .c3   (w_c3)
  );

  assign w_accept  = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_last    = (r_state == RUN) && (r_cnt == CNT_W'(NIBBLES - 1));
  // Sum enters at the MSB end so after NIBBLES shifts the LSB nibble sits at bit 0.
  assign w_shifted = {w_sum, r_result[WIDTH-1:NIBBLE_W]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start)  w_next_state = RUN;
      RUN:     if (w_last) w_next_state = DONE;
      DONE:    w_next_state = start ? RUN : IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_mode   <= 1'b0;
      r_carry  <= 1'b0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
    end else if (w_accept) begin
      r_a      <= a;
      r_b      <= b;
      r_mode   <= mode;
      r_carry  <= mode;
      r_cnt    <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
    end else if (r_state == RUN) begin
      r_result <= w_shifted;
      r_carry  <= w_cout;
      r_a      <= r_a >> NIBBLE_W;
      r_b      <= r_b >> NIBBLE_W;
      r_cnt    <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_cout <= w_cout;
        r_ovf  <= w_c3 ^ w_cout;
        r_zero <= (w_shifted == '0);
      end
    end
  end

  assign busy     = (r_state == RUN);
  assign done     = (r_state == DONE);
  assign result   = r_result;
  assign cout     = r_cout;
  assign overflow = r_ovf;
  assign zero     = r_zero;

endmodule

`default_nettype wire

// File: tb/tb_addsub_nibble_sequencer.sv
// ============================================================================
// Module   : tb_addsub_nibble_sequencer
// Brief    : Directed and random checks of the nibble-serial add/sub sequencer
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_addsub_nibble_sequencer;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        mode;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        cout;
  logic        overflow;
  logic        zero;

  int checks   = 0;
  int failures = 0;

  logic [15:0] exp_r;
  logic        exp_c;
  logic        exp_o;
  logic        exp_z;

  addsub_nibble_sequencer #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .mode     (mode),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .overflow (overflow),
    .zero     (zero)
  );

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on the whole word.
  function automatic void model(input logic [15:0] x, input logic [15:0] y, input logic m,
                                output logic [15:0] r, output logic c, output logic o,
                                output logic z);
    int sx, sy, sr;
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (m) begin
      r  = x - y;
      c  = (x >= y);
      sr = sx - sy;
    end else begin
      r  = x + y;
      c  = (int'(x) + int'(y)) > 65535;
      sr = sx + sy;
    end
    o = (sr > 32767) || (sr < -32768);
    z = (r == 16'd0);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic launch(input logic [15:0] x, input logic [15:0] y, input logic m);
    @(negedge clk);
    start = 1'b1;
    a     = x;
    b     = y;
    mode  = m;
    model(x, y, m, exp_r, exp_c, exp_o, exp_z);
  endtask

  // Follows one operation from its start edge to the done cycle.
  task automatic track(input bit scramble, input string tag);
    @(posedge clk); #1;
    check({tag, ".busy_e0"}, busy, 1);
    check({tag, ".done_e0"}, done, 0);
    for (int k = 1; k < NIB; k++) begin
      @(negedge clk);
      if (scramble) begin
        start = 1'($urandom);
        a     = 16'($urandom);
        b     = 16'($urandom);
        mode  = 1'($urandom);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      check({tag, ".busy_run"}, busy, 1);
      check({tag, ".done_run"}, done, 0);
    end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    check({tag, ".done"},     done,     1);
    check({tag, ".busy_off"}, busy,     0);
    check({tag, ".result"},   result,   exp_r);
    check({tag, ".cout"},     cout,     exp_c);
    check({tag, ".overflow"}, overflow, exp_o);
    check({tag, ".zero"},     zero,     exp_z);
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    check({tag, ".idle_done"}, done,   0);
    check({tag, ".idle_busy"}, busy,   0);
    check({tag, ".held"},      result, exp_r);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    mode  = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.busy",     busy,     0);
    check("reset.done",     done,     0);
    check("reset.result",   result,   0);
    check("reset.cout",     cout,     0);
    check("reset.overflow", overflow, 0);
    check("reset.zero",     zero,     0);
    @(negedge clk);
    rst = 1'b0;

    launch(16'h1234, 16'h0FED, 1'b0); track(1'b0, "add_basic");
    check("add_basic.value", result, 16'h2221);
    idle_check("add_basic");

    // Each launch lands in the previous DONE cycle: back-to-back acceptance.
    launch(16'h0005, 16'h0003, 1'b1); track(1'b1, "sub_pos");
    check("sub_pos.value", result, 16'h0002);
    launch(16'h0004, 16'h0009, 1'b1); track(1'b0, "sub_neg");
    check("sub_neg.value", result, 16'hFFFB);
    launch(16'h7FFF, 16'h0001, 1'b0); track(1'b1, "add_ovf");
    check("add_ovf.flag", overflow, 1);
    launch(16'h8000, 16'h8000, 1'b1); track(1'b0, "sub_zero");
    check("sub_zero.flag", zero, 1);
    launch(16'hFFFF, 16'h0001, 1'b0); track(1'b1, "add_wrap");
    check("add_wrap.cout", cout, 1);
    idle_check("add_wrap");

    // Abort in the second RUN cycle.
    launch(16'h1234, 16'h1111, 1'b0);
    @(posedge clk); #1;
    check("abort.busy_e0", busy, 1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort.busy",     busy,     0);
    check("abort.done",     done,     0);
    check("abort.result",   result,   0);
    check("abort.cout",     cout,     0);
    check("abort.overflow", overflow, 0);
    check("abort.zero",     zero,     0);
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    for (int k = 0; k < NIB + 1; k++) begin
      @(posedge clk); #1;
      check("abort.no_done", done, 0);
    end
    launch(16'h00FF, 16'h0001, 1'b0); track(1'b0, "after_abort");
    check("after_abort.value", result, 16'h0100);
    idle_check("after_abort");

    for (int i = 0; i < 24; i++) begin
      launch(16'($urandom), 16'($urandom), 1'($urandom));
      track(1'($urandom), "random");
      if ($urandom_range(1, 0) == 1) idle_check("random");
    end
    idle_check("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
